// File: rtl/fetch_stage.sv
// Instruction fetch stage of the rvcpu core.
// Keeps the PC, issues one instruction-memory request at a time, buffers the
// returned word in a one-entry output register and hands it to decode over a
// valid/ready handshake. Redirects flush the held entry and discard any
// response still in flight. Misaligned PCs produce a fault entry instead of a
// memory access, after which the stage halts until the next redirect.
module fetch_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,

    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,

    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic [31:0]     fetch_instr,
    output logic            fetch_fault
);

    // REQ: may issue a request; WAIT: response pending for the current pc;
    // DRAIN: a response for a pre-redirect pc is still owed and must be dropped;
    // HALT: misaligned fault delivered, idle until redirected.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]     fetch_instr_q, fetch_instr_d;
    logic            fetch_fault_q, fetch_fault_d;

    logic            pc_aligned;
    logic            out_free;
    logic            req_valid;
    logic            req_fire;

    // Request qualification: only aligned PCs, only when the output register can take the result.
    always_comb begin
        pc_aligned = (pc_q[1:0] == 2'b00);
        out_free   = !fetch_valid_q || fetch_ready;
        req_valid  = !reset && (state_q == S_REQ) && pc_aligned && out_free;
        req_fire   = req_valid && imem_req_ready;
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;
    assign fetch_valid    = fetch_valid_q;
    assign fetch_pc       = fetch_pc_q;
    assign fetch_instr    = fetch_instr_q;
    assign fetch_fault    = fetch_fault_q;

    // Next-state logic for the FSM, PC and output register; redirect is applied last so it wins.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q && !fetch_ready;
        fetch_pc_d    = fetch_pc_q;
        fetch_instr_d = fetch_instr_q;
        fetch_fault_d = fetch_fault_q;

        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end else if (!pc_aligned && out_free) begin
                    fetch_valid_d = 1'b1;
                    fetch_pc_d    = pc_q;
                    fetch_instr_d = 32'h0;
                    fetch_fault_d = 1'b1;
                    state_d       = S_HALT;
                end
            end
            S_WAIT: begin
                // The output register is free here: the request was only issued when it was.
                if (imem_rsp_valid) begin
                    fetch_valid_d = 1'b1;
                    fetch_pc_d    = pc_q;
                    fetch_instr_d = imem_rsp_data;
                    fetch_fault_d = 1'b0;
                    pc_d          = pc_q + XLEN'(4);
                    state_d       = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            pc_d          = redirect_pc;
            fetch_valid_d = 1'b0;
            fetch_pc_d    = fetch_pc_q;
            fetch_instr_d = fetch_instr_q;
            fetch_fault_d = fetch_fault_q;
            case (state_q)
                S_REQ:   state_d = req_fire ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                S_HALT:  state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_instr_q <= 32'h0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural instruction memory with
// programmable response latency, directed scenarios, and a scoreboard whose
// monitor compares every instruction decode consumes against the queue.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int lat      = 1;

    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          cnt = 0;
    logic        seen_stale = 1'b0;
    logic        seen_misaligned = 1'b0;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .fetch_fault    (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Memory contents: two real instructions, a poison word for the stale
    // response, and an address-derived pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0000_0013;
            32'h0000_0004: mem_word = 32'h0010_0093;
            32'h0000_0040: mem_word = 32'hDEAD_BEEF;
            default:       mem_word = {16'hA5A5, a[15:0]};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.fault = fault;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a request handshake seen mid-cycle and check its address.
    task automatic wait_req(input logic [31:0] exp_addr, input string name, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        while (!found && n < 50) begin
            @(negedge clk);
            n++;
            if (imem_req_valid && imem_req_ready) found = 1'b1;
        end
        check({name, "_seen"}, 32'(found), 32'd1);
        if (found) check({name, "_addr"}, imem_req_addr, exp_addr);
    endtask

    task automatic drain_sb(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Drain outstanding expectations, then hold reset and check reset values.
    task automatic do_reset(input string name);
        drain_sb(name);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        fetch_ready    = 1'b0;
        step();
        step();
        @(negedge clk);
        check({name, "_rst_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({name, "_rst_req_addr"}, imem_req_addr, 32'h0);
        check({name, "_rst_fetch_valid"}, 32'(fetch_valid), 32'd0);
        check({name, "_rst_fetch_pc"}, fetch_pc, 32'h0);
        check({name, "_rst_fetch_instr"}, fetch_instr, 32'h0);
        check({name, "_rst_fetch_fault"}, 32'(fetch_fault), 32'd0);
        step();
        reset = 1'b0;
    endtask

    // Instruction memory model: one outstanding request, response after lat cycles.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr);
                    pend           = 1'b0;
                end else begin
                    cnt--;
                end
            end
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else if (imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                pend_addr = imem_req_addr;
                cnt       = lat;
                if (imem_req_addr[1:0] != 2'b00) seen_misaligned = 1'b1;
            end
        end
    end

    // Monitor: every instruction decode consumes is compared against the scoreboard.
    always @(negedge clk) begin
        logic have;
        exp_t e;
        if (!reset && fetch_valid && fetch_instr == 32'hDEAD_BEEF) seen_stale = 1'b1;
        if (!reset && fetch_valid && fetch_ready && !redirect_valid) begin
            have = (sb.size() != 0);
            check("fetch_expected", 32'(have), 32'd1);
            if (have) begin
                e = sb.pop_front();
                check("fetch_pc", fetch_pc, e.pc);
                check("fetch_instr", fetch_instr, e.instr);
                check("fetch_fault", 32'(fetch_fault), 32'(e.fault));
            end
        end
    end

    initial begin
        int n;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        fetch_ready    = 1'b0;

        // Streaming fetch with a one-cycle memory.
        do_reset("a");
        lat = 1;
        imem_req_ready = 1'b1;
        fetch_ready    = 1'b1;
        push(32'h0, 32'h0000_0013, 1'b0);
        push(32'h4, 32'h0010_0093, 1'b0);
        push(32'h8, mem_word(32'h8), 1'b0);
        wait_req(32'h0, "a_req0", n);
        step();
        wait_req(32'h4, "a_req4", n);
        check("a_throughput", 32'(n), 32'd2);
        step();
        wait_req(32'h8, "a_req8", n);
        step();
        imem_req_ready = 1'b0;

        // Decode backpressure holds the entry and blocks new requests.
        do_reset("b");
        lat = 1;
        imem_req_ready = 1'b1;
        wait_req(32'h0, "b_req0", n);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b_hold_valid", 32'(fetch_valid), 32'd1);
            check("b_hold_pc", fetch_pc, 32'h0);
            check("b_hold_instr", fetch_instr, 32'h0000_0013);
            check("b_hold_no_req", 32'(imem_req_valid), 32'd0);
            step();
        end
        push(32'h0, 32'h0000_0013, 1'b0);
        push(32'h4, 32'h0010_0093, 1'b0);
        fetch_ready = 1'b1;
        wait_req(32'h4, "b_resume", n);
        check("b_resume_same_cycle", 32'(n), 32'd1);
        step();
        imem_req_ready = 1'b0;

        // Redirect while waiting: the stale response must be discarded.
        do_reset("c");
        lat = 3;
        fetch_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        wait_req(32'h40, "c_req40", n);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        push(32'h100, mem_word(32'h100), 1'b0);
        wait_req(32'h100, "c_req100", n);
        check("c_drain_wait", 32'(n), 32'd3);
        step();
        imem_req_ready = 1'b0;

        // Redirect flushes a held entry that decode has not taken.
        do_reset("d");
        lat = 1;
        imem_req_ready = 1'b1;
        wait_req(32'h0, "d_req0", n);
        step();
        step();
        @(negedge clk);
        check("d_held", 32'(fetch_valid), 32'd1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("d_flushed", 32'(fetch_valid), 32'd0);
        check("d_req_valid", 32'(imem_req_valid), 32'd1);
        check("d_req_addr", imem_req_addr, 32'h200);
        push(32'h200, mem_word(32'h200), 1'b0);
        step();
        imem_req_ready = 1'b0;
        fetch_ready    = 1'b1;

        // Misaligned redirect target: fault entry, halt, recover on redirect.
        do_reset("e");
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("e_no_req", 32'(imem_req_valid), 32'd0);
        step();
        @(negedge clk);
        check("e_fault_valid", 32'(fetch_valid), 32'd1);
        check("e_fault_flag", 32'(fetch_fault), 32'd1);
        check("e_fault_pc", fetch_pc, 32'h102);
        check("e_fault_instr", fetch_instr, 32'h0);
        check("e_fault_no_req", 32'(imem_req_valid), 32'd0);
        step();
        step();
        @(negedge clk);
        check("e_halt_hold", 32'(fetch_valid), 32'd1);
        check("e_halt_hold_no_req", 32'(imem_req_valid), 32'd0);
        step();
        push(32'h102, 32'h0, 1'b1);
        fetch_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check("e_halt_empty", 32'(fetch_valid), 32'd0);
        check("e_halt_no_req", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        push(32'h300, mem_word(32'h300), 1'b0);
        step();
        redirect_valid = 1'b0;
        wait_req(32'h300, "e_req300", n);
        step();
        imem_req_ready = 1'b0;

        // PC wrap at the top of the address space, then reset during WAIT.
        do_reset("f");
        lat = 3;
        fetch_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        push(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1'b0);
        wait_req(32'hFFFF_FFFC, "f_req_top", n);
        step();
        wait_req(32'h0, "f_pc_wrap", n);
        step();
        do_reset("f_mid");
        lat = 1;
        fetch_ready    = 1'b1;
        imem_req_ready = 1'b1;
        push(32'h0, 32'h0000_0013, 1'b0);
        wait_req(32'h0, "f_req_after_reset", n);
        check("f_req_immediate", 32'(n), 32'd1);
        step();
        imem_req_ready = 1'b0;

        drain_sb("end");
        check("no_stale_word", 32'(seen_stale), 32'd0);
        check("no_misaligned_access", 32'(seen_misaligned), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the rvcpu core.
- Holds the PC and issues one instruction-memory request at a time.
- Buffers the returned word in a one-entry output register, then hands it to decode (immediate generation and register-file read) over a valid/ready handshake.
- Handles control-flow redirects, including discarding in-flight responses, and flags misaligned fetch addresses.

Parameters:
- XLEN, 32, width of PC and addresses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- redirect_valid  input  1  one-cycle pulse that loads a new PC (branch, jump or trap).
- redirect_pc  input  XLEN  target PC, sampled when redirect_valid=1.
- imem_req_valid  output  1  request to instruction memory.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  XLEN  fetch address; always equals pc.
- imem_rsp_valid  input  1  response word valid; one response per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- fetch_valid  output  1  output register holds an instruction.
- fetch_ready  input  1  decode consumes the output register.
- fetch_pc  output  XLEN  PC of the held instruction.
- fetch_instr  output  32  held instruction word.
- fetch_fault  output  1  held entry is an instruction-address-misaligned fault.

Behaviour:
- Clock and reset: single clock `clk`. `reset` is synchronous and active-high.
- Reset values:
  - pc=RESET_PC, state=REQ.
  - fetch_valid=0, fetch_pc=0, fetch_instr=0, fetch_fault=0.
  - imem_req_valid=0 while reset is high.
- State REQ:
  - imem_req_valid = (pc[1:0]==0) && (!fetch_valid || fetch_ready).
  - On handshake (valid && ready), go to WAIT.
  - If pc[1:0]!=0 and the output register is free (empty or consumed this cycle): load the output register with fault=1, instr=0, pc=pc; go to HALT; issue no request.
- State WAIT:
  - On imem_rsp_valid: load the output register (valid=1, instr=rsp_data, pc=pc, fault=0); pc<=pc+4; go to REQ.
  - The output register is always free at this point; a request is only issued when it is empty or being consumed.
- State DRAIN:
  - Wait for the stale response and discard it (output register unchanged); go to REQ.
- State HALT:
  - No requests issued.
  - Leave only on redirect.
- Output register:
  - fetch_valid clears on fetch_ready when no new load occurs in the same cycle.
  - A load and a consume in the same cycle leave it valid with the new contents.
  - Contents are stable while fetch_valid=1 && fetch_ready=0.
- PC arithmetic: pc+4 wraps modulo 2^XLEN; no overflow flag.
- Redirect (highest priority over all other events in the same cycle):
  - pc<=redirect_pc and fetch_valid<=0 (the held entry is flushed even if fetch_ready=1 in that cycle).
  - REQ, no handshake in the same cycle → REQ.
  - REQ, handshake in the same cycle → DRAIN (the request already issued to the old pc).
  - WAIT without rsp_valid → DRAIN.
  - WAIT with rsp_valid → REQ (the response is dropped).
  - DRAIN without rsp_valid → stay in DRAIN.
  - DRAIN with rsp_valid → REQ.
  - HALT → REQ.
- Misaligned redirect target: handled by the REQ fault path above; no memory access is ever made to a misaligned address.
- Reset mid-operation: reset overrides redirect and returns to reset values. An outstanding memory response after reset is the memory's responsibility; memory is reset in the same cycle.
- Throughput:
  - 1 instruction per 2 cycles with a zero-wait memory (REQ→WAIT→REQ).
  - Latency from request acceptance to fetch_valid = response latency + 1 cycle.

Test Plan:
- Reset release, imem_req_ready=1, rsp 1 cycle later, fetch_ready=1, rsp words 0x00000013, 0x00100093 → fetch outputs (pc=0x0, instr=0x00000013), then (pc=0x4, instr=0x00100093); imem_req_addr sequence 0x0, 0x4, 0x8.
- fetch_ready held 0 after the first fetch → fetch_valid stays 1 with pc/instr stable; imem_req_valid=0; resumes with a request to 0x4 in the cycle fetch_ready returns to 1.
- Redirect to 0x100 in WAIT, stale response 0xDEADBEEF arrives 2 cycles later → 0xDEADBEEF never appears on fetch_instr; next request addr=0x100; next fetch pc=0x100.
- Redirect to 0x200 with fetch_valid=1 and fetch_ready=0 → fetch_valid=0 next cycle; next request addr=0x200.
- Redirect to 0x102 → no imem request; fetch_valid=1, fetch_fault=1, fetch_pc=0x102, instr=0; stays in HALT until redirect to 0x300, then requests 0x300.
- pc=0xFFFFFFFC, response accepted → next request addr=0x00000000; reset asserted during WAIT → fetch_valid=0 and next request addr=RESET_PC.
